mau_mem_slave: RTL

- AHB-Lite-style data-memory responder at the far end of the MAU bus master interface (HADDR/HWDATA/HRDATA/HTRANS/HWRITE/HSIZE/HRESP/HREADY).
- Services the LOAD/STORE traffic issued by the core's MAU.
- Holds a word-organised register-array memory with byte-lane writes and configurable wait states.
- Returns two-cycle ERROR responses for illegal transfers.

---
 rtl/mau_bus_pkg.sv | 44 ++++
 rtl/mau_mem_array.sv | 27 ++
 rtl/mau_mem_slave.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mau_bus_pkg.sv
// Shared MAU bus definitions: transfer/response/size codes, the data-memory
// responder state encoding, and the byte-lane mask helper.
package mau_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } mem_state_e;

  // Byte lanes touched by a transfer of the given size at byte offset lo.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] m;
    m = '0;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_mem_array.sv
// Word-organised register-array memory.
// Ports: clk; we[3:0] byte-lane write enables; waddr/wdata write port
// (commits on the rising edge); raddr/rdata combinational read port.
// Contents are never reset.
module mau_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mau_mem_slave.sv
// AHB-Lite-style data-memory responder for MAU LOAD/STORE traffic.
// Ports: HCLK, HRESETn (sync, active-low); address phase HSEL/HADDR/HTRANS/
// HWRITE/HSIZE/HREADY; data phase HWDATA in, HRDATA/HREADYOUT/HRESP out.
// Legal transfers get WAIT_STATES wait cycles then an OKAY data phase;
// illegal ones get a two-cycle ERROR response with no memory access.
module mau_mem_slave
  import mau_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES - 1);

  mem_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [1:0]      lo_q;
  logic [2:0]      size_q;
  logic            write_q;
  logic            latch;

  logic [31:0]     offset;
  logic            accept, in_range, align_ok, legal;
  logic [3:0]      we;
  logic [31:0]     rdata;

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
  assign offset   = HADDR - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign accept   = HSEL & HREADY & HTRANS[1];

  always_comb begin
    align_ok = 1'b0;
    case (HSIZE)
      SIZE_BYTE: align_ok = 1'b1;
      SIZE_HALF: align_ok = ~HADDR[0];
      SIZE_WORD: align_ok = (HADDR[1:0] == 2'b00);
      default:   align_ok = 1'b0;
    endcase
  end

  assign legal = in_range & align_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete with HREADYOUT high, so each
        // can take the next address phase on the same edge.
        if (accept) begin
          latch = 1'b1;
          if (!legal)                state_d = ST_ERR1;
          else if (WAIT_STATES == 0) state_d = ST_DATA;
          else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q   <= offset[AW+1:2];
        lo_q    <= offset[1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  assign we = (state_q == ST_DATA && write_q) ? lane_mask(size_q, lo_q) : '0;

  mau_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .raddr (idx_q),
    .rdata (rdata)
  );

  always_comb begin
    HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
    HRDATA    = (state_q == ST_DATA && !write_q) ? rdata : '0;
  end

endmodule
